integral_buffer: RTL and testbench
==================================

INTEGRAL_BUFFER -- requirements
Module: integral_buffer

Interface
REQ-001 Parameter IMG_W, default 64, frame width in pixels.
REQ-002 Parameter IMG_H, default 48, frame height in pixels; IMG_W*IMG_H SHALL be at most 32768.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse; begins a new frame fill.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_in  input  8  unsigned grayscale pixel, raster order.
REQ-008 pix_ready  output  1  high when pixels are being accepted.
REQ-009 fill_done  output  1  one-cycle pulse when the last pixel's integral value is stored.
REQ-010 frame_ready  output  1  level; the stored integral image is complete and readable.
REQ-011 frame_abort  output  1  one-cycle pulse when frame_start interrupts a fill.
REQ-012 rd_addr  input  15  read address from the classifier.
REQ-013 data_out  output  21  integral value at rd_addr, returned 3 cycles later.

Function
REQ-014 States SHALL be IDLE, FILL and READY, one-hot encoded.
REQ-015 IDLE->FILL on frame_start; FILL->READY when pixel IMG_W*IMG_H-1 is stored; READY->FILL on frame_start.
REQ-016 frame_start in FILL SHALL restart the fill at pixel 0, clear the counters, and pulse frame_abort in the next cycle.
REQ-017 pix_ready SHALL equal 1 in FILL and 0 otherwise; pix_valid SHALL be ignored while pix_ready is 0.
REQ-018 Each accepted pixel at (x,y) SHALL store I(x,y) = rowsum(x,y) + I(x,y-1), where rowsum is the running sum of pix_in over row y, columns 0..x.
REQ-019 The first row (y=0) SHALL use I(x,-1) = 0.
REQ-020 I(x,y-1) SHALL come from an internal IMG_W x 21-bit line buffer, not from the main memory read port.
REQ-021 The write address SHALL be y*IMG_W+x.
REQ-022 The x counter SHALL wrap to 0 at IMG_W-1, increment y, and clear rowsum.
REQ-023 All arithmetic SHALL be unsigned 21-bit; overflow cannot occur at the default size (max 783360).
REQ-024 The write of I(x,y) SHALL complete within 2 cycles of pixel acceptance.
REQ-025 fill_done SHALL pulse exactly once, in the cycle after the final write; frame_ready SHALL rise in that same cycle.
REQ-026 frame_ready SHALL stay high in READY and fall in the cycle after frame_start.
REQ-027 Read latency SHALL be exactly 3 cycles:
- cycle 1: register rd_addr;
- cycle 2: memory read;
- cycle 3: output register.
REQ-028 The read port SHALL be fully pipelined, accepting a new rd_addr every cycle in every state.
REQ-029 rd_addr >= IMG_W*IMG_H SHALL return 0.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old contents.
REQ-031 Reads during FILL SHALL return the current memory contents; the buffer gives no coherence guarantee until frame_ready.

Reset
REQ-032 While rst is high:
- state = IDLE;
- pix_ready, fill_done, frame_ready, frame_abort = 0;
- data_out = 0;
- counters, rowsum and the read pipeline cleared.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-fill SHALL abandon the frame; after reset, a frame_start is required before filling.

Verification
REQ-035 All-ones frame (pix_in=1, 64x48, continuous pix_valid): read addr 0 -> 1, 63 -> 64, 64 -> 2, 3071 -> 3072; fill_done pulses once, 3072 accepted pixels after the first.
REQ-036 Read latency: rd_addr stepping 0,1,2,... every cycle in READY -> data_out shows I(0),I(1),I(2)... starting exactly 3 cycles after each address; rd_addr=4000 -> 0.
REQ-037 pix_in=255 everywhere -> addr 3071 reads 783360 with no wrap; gapped pix_valid (1 of every 3 cycles) -> identical memory contents.
REQ-038 frame_start at pixel 100 of a fill -> frame_abort pulses; the refill with pix_in=2 gives addr 3071 = 6144; fill_done pulses only for the completed frame.
REQ-039 rst asserted at pixel 500 -> all outputs 0 immediately; pixels ignored until frame_start; the subsequent fill is correct.
REQ-040 Same-cycle read and write to addr 10 in FILL -> data_out returns the pre-write value.

Source files
------------

// File: rtl/integral_buffer.sv
// Integral-image frame buffer.
// Accepts one grayscale frame in raster order and stores the summed-area table
// I(x,y) = sum of all pixels at or above-left of (x,y). The row above is held
// in a small line buffer, so the main memory needs only one write port and one
// read port. Reads pass through a 3-stage pipeline: address register, memory
// read, output register.
module integral_buffer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_in,
    output logic        pix_ready,
    output logic        fill_done,
    output logic        frame_ready,
    output logic        frame_abort,
    input  logic [14:0] rd_addr,
    output logic [20:0] data_out
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [14:0]   A_LAST  = 15'(NPIX - 1);
    localparam logic [15:0]   A_LIMIT = 16'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_FILL  = 3'b010,
        S_READY = 3'b100
    } state_t;

    state_t state_q, state_d;

    // Storage: full integral image plus one row of the previous line.
    logic [20:0] mem_q [NPIX];
    logic [20:0] lb_q  [IMG_W];

    // Fill-side counters and running row sum.
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [14:0]   addr_q;
    logic [20:0]   rowsum_q;

    logic fill_done_q;
    logic frame_ready_q;
    logic frame_abort_q;

    // Read pipeline.
    logic [14:0] rd_addr_q;
    logic        rd_hit_q;
    logic [20:0] rd_data_q;
    logic [20:0] data_out_q;

    logic        accept_s;
    logic        last_s;
    logic [20:0] rowsum_new_s;
    logic [20:0] above_s;
    logic [20:0] integ_s;

    // A pixel arriving together with frame_start is dropped: the restart wins.
    assign accept_s     = (state_q == S_FILL) && pix_valid && !frame_start;
    assign last_s       = (addr_q == A_LAST);
    assign rowsum_new_s = rowsum_q + {13'd0, pix_in};
    assign above_s      = (y_q == {YW{1'b0}}) ? 21'd0 : lb_q[x_q];
    assign integ_s      = rowsum_new_s + above_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame_start always (re)enters FILL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_FILL;
                else             state_d = S_IDLE;
            end
            S_FILL: begin
                if (frame_start)           state_d = S_FILL;
                else if (accept_s && last_s) state_d = S_READY;
                else                       state_d = S_FILL;
            end
            S_READY: begin
                if (frame_start) state_d = S_FILL;
                else             state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Raster counters and row sum; cleared whenever a new frame begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
            addr_q   <= 15'd0;
            rowsum_q <= 21'd0;
        end else if (frame_start) begin
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
            addr_q   <= 15'd0;
            rowsum_q <= 21'd0;
        end else if (accept_s) begin
            addr_q <= addr_q + 15'd1;
            if (x_q == X_LAST) begin
                x_q      <= {XW{1'b0}};
                y_q      <= y_q + YW'(1);
                rowsum_q <= 21'd0;
            end else begin
                x_q      <= x_q + XW'(1);
                rowsum_q <= rowsum_new_s;
            end
        end
    end

    // Status flags: completion pulse, ready level, abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_done_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            fill_done_q   <= accept_s && last_s;
            frame_abort_q <= frame_start && (state_q == S_FILL);
            if (frame_start) begin
                frame_ready_q <= 1'b0;
            end else if (accept_s && last_s) begin
                frame_ready_q <= 1'b1;
            end
        end
    end

    // Integral value is written in the accepting cycle; memory is never reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[addr_q[AW-1:0]] <= integ_s;
            lb_q[x_q]             <= integ_s;
        end
    end

    // Read pipeline: address register, memory read (old data on collision), output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q  <= 15'd0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= 21'd0;
            data_out_q <= 21'd0;
        end else begin
            rd_addr_q  <= rd_addr;
            rd_hit_q   <= ({1'b0, rd_addr_q} < A_LIMIT);
            rd_data_q  <= mem_q[rd_addr_q[AW-1:0]];
            data_out_q <= rd_hit_q ? rd_data_q : 21'd0;
        end
    end

    assign pix_ready   = (state_q == S_FILL);
    assign fill_done   = fill_done_q;
    assign frame_ready = frame_ready_q;
    assign frame_abort = frame_abort_q;
    assign data_out    = data_out_q;

endmodule

// File: tb/tb_integral_buffer.sv
// Self-checking bench for integral_buffer: random and directed frames are
// compared against a summed-area-table model built by inclusion-exclusion.
module tb_integral_buffer;

    localparam int W = 64;
    localparam int H = 48;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic        pix_ready;
    logic        fill_done;
    logic        frame_ready;
    logic        frame_abort;
    logic [14:0] rd_addr;
    logic [20:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int pix_m [N];
    int img_m [N];
    int expq [$];

    integral_buffer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .pix_ready   (pix_ready),
        .fill_done   (fill_done),
        .frame_ready (frame_ready),
        .frame_abort (frame_abort),
        .rd_addr     (rd_addr),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    // Count completion and abort pulses seen on the clock edge.
    always @(posedge clk) begin
        if (fill_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Summed-area table: I = p + left + up - upleft.
    function automatic void build_model;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int idx;
                int a;
                idx = y * W + x;
                a = pix_m[idx];
                if (x > 0) a += img_m[idx - 1];
                if (y > 0) a += img_m[idx - W];
                if (x > 0 && y > 0) a -= img_m[idx - W - 1];
                img_m[idx] = a;
            end
        end
    endfunction

    function automatic int ref_val(input int a);
        return (a >= 0 && a < N) ? img_m[a] : 0;
    endfunction

    task automatic rd_check(input string tag, input int a, input int exp);
        rd_addr = 15'(a);
        tick;
        tick;
        tick;
        check(tag, data_out, exp);
    endtask

    task automatic fill_frame(input bit rnd, input logic [7:0] cval, input bit gap,
                              input int stop_at, input bit exp_abort,
                              input bit rw, input int rw_old);
        int n;
        int cyc;
        int nb;
        logic v;
        logic [7:0] p;
        n = 0;
        cyc = 0;
        frame_start = 1'b1;
        pix_valid = 1'b0;
        tick;
        frame_start = 1'b0;
        check("abort_pulse", frame_abort, exp_abort);
        check("ready_in_fill", pix_ready, 1);
        check("frame_ready_fall", frame_ready, 0);
        while (n < stop_at && cyc < 4 * N + 16) begin
            v = gap ? (cyc % 3 == 0) : 1'b1;
            p = rnd ? 8'($urandom_range(0, 255)) : cval;
            pix_valid = v;
            pix_in = p;
            nb = n;
            if (rw) rd_addr = (nb == 9) ? 15'd10 : 15'd0;
            tick;
            if (v) begin
                pix_m[n] = p;
                n++;
            end
            if (cyc == 0) check("abort_once", frame_abort, 0);
            if (rw && nb == 11) check("rw_old", data_out, rw_old);
            if (v && n == N) begin
                check("fill_done_pulse", fill_done, 1);
                check("frame_ready_rise", frame_ready, 1);
                check("ready_drop", pix_ready, 0);
            end
            cyc++;
        end
        pix_valid = 1'b0;
        check("fill_count", n, stop_at);
        if (stop_at == N) begin
            tick;
            check("done_single", fill_done, 0);
            check("frame_ready_hold", frame_ready, 1);
            build_model();
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_in = 8'd0;
        rd_addr = 15'd0;
        #2;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_frame_abort", frame_abort, 0);
        check("rst_data_out", data_out, 0);
        tick;
        tick;
        rst = 1'b0;

        // Pixels offered in IDLE are not accepted.
        pix_valid = 1'b1;
        pix_in = 8'd9;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("ready_idle", pix_ready, 0);
        end
        pix_valid = 1'b0;

        // All-ones frame with continuous valid.
        fill_frame(1'b0, 8'd1, 1'b0, N, 1'b0, 1'b0, 0);
        check("done_cnt_1", done_cnt, 1);
        rd_check("ones_0", 0, 1);
        rd_check("ones_63", 63, 64);
        rd_check("ones_64", 64, 2);
        rd_check("ones_3071", 3071, 3072);
        rd_check("ones_model_1000", 1000, ref_val(1000));

        // Back-to-back reads: each address returns exactly 3 cycles later.
        for (int j = 0; j < 44; j++) begin
            int a;
            a = (j == 20) ? 4000 : ((j < 40) ? j : 0);
            rd_addr = 15'(a);
            expq.push_back(ref_val(a));
            tick;
            if (expq.size() == 3) check("stream", data_out, expq.pop_front());
        end
        rd_check("oob_4000", 4000, 0);
        rd_check("oob_32767", 32767, 0);
        rd_check("oob_3072", 3072, 0);

        // Full-scale frame; also a same-cycle read/write at address 10.
        fill_frame(1'b0, 8'd255, 1'b0, N, 1'b0, 1'b1, 11);
        rd_check("max_3071", 3071, 783360);
        rd_check("max_10", 10, 2805);
        check("done_cnt_2", done_cnt, 2);

        // Random frame with pixels offered one cycle in three.
        fill_frame(1'b1, 8'd0, 1'b1, N, 1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            int a;
            a = $urandom_range(0, N - 1);
            rd_check("gap_rand", a, ref_val(a));
        end
        rd_check("gap_3071", 3071, ref_val(3071));
        check("done_cnt_3", done_cnt, 3);

        // Restart mid-fill; only the completed frame reports done.
        fill_frame(1'b1, 8'd0, 1'b0, 100, 1'b0, 1'b0, 0);
        fill_frame(1'b0, 8'd2, 1'b0, N, 1'b1, 1'b0, 0);
        check("abort_cnt", abort_cnt, 1);
        rd_check("twos_3071", 3071, 6144);
        rd_check("twos_model_777", 777, ref_val(777));
        check("done_cnt_4", done_cnt, 4);

        // Reset in the middle of a fill.
        fill_frame(1'b1, 8'd0, 1'b0, 500, 1'b0, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("mrst_pix_ready", pix_ready, 0);
        check("mrst_fill_done", fill_done, 0);
        check("mrst_frame_ready", frame_ready, 0);
        check("mrst_frame_abort", frame_abort, 0);
        check("mrst_data_out", data_out, 0);
        tick;
        rst = 1'b0;
        pix_valid = 1'b1;
        pix_in = 8'd77;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("ready_after_rst", pix_ready, 0);
        end
        pix_valid = 1'b0;
        fill_frame(1'b1, 8'd0, 1'b0, N, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            int a;
            a = $urandom_range(0, N - 1);
            rd_check("post_rst_rand", a, ref_val(a));
        end
        rd_check("post_rst_0", 0, ref_val(0));
        rd_check("post_rst_3071", 3071, ref_val(3071));
        check("done_cnt_5", done_cnt, 5);
        check("abort_cnt_final", abort_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
